// File: rtl/al_ptr_ctrl_pkg.sv
// Shared constants, pointer types and the modulo pointer-add helper for the active-list controller.
package al_pkg;

    localparam int AL_DEPTH  = 16;
    localparam int AL_INDEX  = 4;
    localparam int AL_DATA_W = 8;

    typedef logic [AL_INDEX-1:0] alPtr_t;
    typedef logic [AL_INDEX:0]   alCnt_t;

    // DEPTH is a power of two, so dropping the carry out is the wrap.
    function automatic alPtr_t alWrap(input alPtr_t ptr, input alPtr_t off);
        return ptr + off;
    endfunction

endpackage

// File: rtl/al_ptr_ctrl_if.sv
// Dispatch, RAM-port and commit signals of the active-list pointer controller.
interface al_ptr_ctrl_if
    import al_pkg::*;
#(
    parameter int INDEX          = AL_INDEX,
    parameter int DISPATCH_WIDTH = 4,
    parameter int COMMIT_WIDTH   = 4,
    parameter int DATA_W         = AL_DATA_W
);
    logic                               flush_i;
    logic                               dispValid_i;
    logic [3:0]                         dispCnt_i;
    logic [DISPATCH_WIDTH*DATA_W-1:0]   data_i;
    logic [DISPATCH_WIDTH*INDEX-1:0]    addrWr_o;
    logic [DISPATCH_WIDTH*DATA_W-1:0]   dataWr_o;
    logic [DISPATCH_WIDTH-1:0]          we_o;
    logic                               dispAccept_o;
    logic [INDEX-1:0]                   alId_o;
    logic [2:0]                         commitCnt_i;
    logic [COMMIT_WIDTH*INDEX-1:0]      addrRd_o;
    logic [INDEX-1:0]                   head_o;
    logic [INDEX:0]                     count_o;
    logic                               full_o;
    logic                               empty_o;
    logic                               commitErr_o;

    modport master (
        output flush_i, dispValid_i, dispCnt_i, data_i, commitCnt_i,
        input  addrWr_o, dataWr_o, we_o, dispAccept_o, alId_o,
        input  addrRd_o, head_o, count_o, full_o, empty_o, commitErr_o
    );

    modport slave (
        input  flush_i, dispValid_i, dispCnt_i, data_i, commitCnt_i,
        output addrWr_o, dataWr_o, we_o, dispAccept_o, alId_o,
        output addrRd_o, head_o, count_o, full_o, empty_o, commitErr_o
    );

endinterface

// File: rtl/al_ptr_ctrl_lane_addr_gen.sv
// Expands a base pointer into LANES consecutive, wrapped RAM addresses.
module al_lane_addr_gen
    import al_pkg::*;
#(
    parameter int LANES = 4,
    parameter int INDEX = AL_INDEX
) (
    input  logic [INDEX-1:0]       base_i,
    output logic [LANES*INDEX-1:0] addr_o
);

    always_comb begin
        addr_o = '0;
        for (int i = 0; i < LANES; i++) begin
            addr_o[i*INDEX +: INDEX] = base_i + INDEX'(i);
        end
    end

endmodule

// File: rtl/al_ptr_ctrl.sv
// Active-list head/tail pointer controller: multi-lane allocation at the tail,
// multi-lane retire at the head, occupancy tracking, back-pressure and flush.
module al_ptr_ctrl
    import al_pkg::*;
#(
    parameter int DEPTH          = AL_DEPTH,
    parameter int INDEX          = AL_INDEX,
    parameter int DISPATCH_WIDTH = 4,
    parameter int COMMIT_WIDTH   = 4
) (
    input  logic          clk,
    input  logic          reset,
    al_ptr_ctrl_if.slave  bus
);

    localparam int CW = INDEX + 1;

    logic [INDEX-1:0]                head_q, head_d;
    logic [INDEX-1:0]                tail_q, tail_d;
    logic [CW-1:0]                   count_q, count_d;
    logic                            full_q, full_d;

    logic [3:0]                      disp_cnt;
    logic [CW-1:0]                   commit_ext;
    logic [CW-1:0]                   eff_c;
    logic [CW-1:0]                   disp_n;
    logic                            commit_err;
    logic                            accept;
    logic [DISPATCH_WIDTH-1:0]       we;
    logic [DISPATCH_WIDTH*INDEX-1:0] addr_wr;
    logic [COMMIT_WIDTH*INDEX-1:0]   addr_rd;

    always_comb begin
        disp_cnt   = (bus.dispCnt_i > 4'(DISPATCH_WIDTH)) ? 4'(DISPATCH_WIDTH) : bus.dispCnt_i;
        commit_ext = CW'(bus.commitCnt_i);
        commit_err = commit_ext > count_q;
        eff_c      = commit_err ? count_q : commit_ext;
        // full_q reflects last cycle's count, so same-cycle commits cannot unblock dispatch.
        accept     = bus.dispValid_i & ~bus.flush_i & ~full_q & (bus.dispCnt_i != 4'd0) & ~reset;
        disp_n     = accept ? CW'(disp_cnt) : '0;

        we = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            we[i] = accept & (4'(i) < disp_cnt);
        end

        head_d  = alWrap(head_q, eff_c[INDEX-1:0]);
        tail_d  = alWrap(tail_q, disp_n[INDEX-1:0]);
        count_d = count_q + disp_n - eff_c;
        full_d  = count_d > CW'(DEPTH - DISPATCH_WIDTH);
        if (bus.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            full_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    al_lane_addr_gen #(.LANES(DISPATCH_WIDTH), .INDEX(INDEX)) u_wr_addr (
        .base_i (tail_q),
        .addr_o (addr_wr)
    );

    al_lane_addr_gen #(.LANES(COMMIT_WIDTH), .INDEX(INDEX)) u_rd_addr (
        .base_i (head_q),
        .addr_o (addr_rd)
    );

    assign bus.addrWr_o     = addr_wr;
    assign bus.dataWr_o     = bus.data_i;
    assign bus.we_o         = we;
    assign bus.dispAccept_o = accept;
    assign bus.alId_o       = tail_q;
    assign bus.addrRd_o     = addr_rd;
    assign bus.head_o       = head_q;
    assign bus.count_o      = count_q;
    assign bus.full_o       = full_q;
    assign bus.empty_o      = (count_q == '0);
    assign bus.commitErr_o  = commit_err & ~bus.flush_i & ~reset;

`ifndef SYNTHESIS
    logic [INDEX-1:0] tail_exp;
    assign tail_exp = head_q + count_q[INDEX-1:0];

    assert property (@(posedge clk) disable iff (reset)
        (count_q <= CW'(DEPTH)) && (tail_q == tail_exp));
`endif

endmodule

// File: tb/tb_al_ptr_ctrl.sv
// Directed bench for al_ptr_ctrl with hand-computed expectations at each step.
module tb_al_ptr_ctrl;
    import al_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    al_ptr_ctrl_if #(.INDEX(4), .DISPATCH_WIDTH(4), .COMMIT_WIDTH(4)) bus_if ();

    al_ptr_ctrl #(.DEPTH(16), .INDEX(4), .DISPATCH_WIDTH(4), .COMMIT_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [3:0] cnt, input logic [2:0] cc, input logic fl);
        @(negedge clk);
        bus_if.dispValid_i = v;
        bus_if.dispCnt_i   = cnt;
        bus_if.commitCnt_i = cc;
        bus_if.flush_i     = fl;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_if.flush_i     = 1'b0;
        bus_if.dispValid_i = 1'b1;
        bus_if.dispCnt_i   = 4'd3;
        bus_if.commitCnt_i = 3'd2;
        bus_if.data_i      = 32'hA3A2A1A0;
        #12;
        chk("rst_count",     32'(bus_if.count_o),      32'd0);
        chk("rst_empty",     32'(bus_if.empty_o),      32'd1);
        chk("rst_full",      32'(bus_if.full_o),       32'd0);
        chk("rst_we",        32'(bus_if.we_o),         32'd0);
        chk("rst_accept",    32'(bus_if.dispAccept_o), 32'd0);
        chk("rst_commitErr", 32'(bus_if.commitErr_o),  32'd0);

        drive(1'b0, 4'd0, 3'd0, 1'b0);
        reset = 1'b0;
        edge_step();
        chk("idle_count",  32'(bus_if.count_o),  32'd0);
        chk("idle_empty",  32'(bus_if.empty_o),  32'd1);
        chk("idle_full",   32'(bus_if.full_o),   32'd0);
        chk("idle_addrRd", 32'(bus_if.addrRd_o), 32'h3210);
        chk("idle_we",     32'(bus_if.we_o),     32'd0);

        // dispatch 3 at tail 0
        drive(1'b1, 4'd3, 3'd0, 1'b0);
        chk("d3_we",     32'(bus_if.we_o),         32'h7);
        chk("d3_addrWr", 32'(bus_if.addrWr_o),     32'h3210);
        chk("d3_alId",   32'(bus_if.alId_o),       32'd0);
        chk("d3_accept", 32'(bus_if.dispAccept_o), 32'd1);
        chk("d3_dataWr", 32'(bus_if.dataWr_o),     32'hA3A2A1A0);
        edge_step();
        chk("d3_count", 32'(bus_if.count_o),        32'd3);
        chk("d3_tail",  32'(bus_if.addrWr_o[3:0]),  32'd3);
        chk("d3_empty", 32'(bus_if.empty_o),        32'd0);

        // fill 3 -> 7 -> 11 -> 13
        drive(1'b1, 4'd4, 3'd0, 1'b0);
        chk("f7_addrWr", 32'(bus_if.addrWr_o), 32'h6543);
        chk("f7_we",     32'(bus_if.we_o),     32'hF);
        edge_step();
        drive(1'b1, 4'd4, 3'd0, 1'b0);
        edge_step();
        chk("f11_count", 32'(bus_if.count_o), 32'd11);
        chk("f11_full",  32'(bus_if.full_o),  32'd0);
        drive(1'b1, 4'd2, 3'd0, 1'b0);
        edge_step();
        chk("f13_count", 32'(bus_if.count_o),       32'd13);
        chk("f13_full",  32'(bus_if.full_o),        32'd1);
        chk("f13_tail",  32'(bus_if.addrWr_o[3:0]), 32'd13);

        // blocked dispatch while committing 2
        drive(1'b1, 4'd1, 3'd2, 1'b0);
        chk("blk_full",   32'(bus_if.full_o),       32'd1);
        chk("blk_accept", 32'(bus_if.dispAccept_o), 32'd0);
        chk("blk_we",     32'(bus_if.we_o),         32'd0);
        edge_step();
        chk("blk_count", 32'(bus_if.count_o), 32'd11);
        chk("blk_full2", 32'(bus_if.full_o),  32'd0);
        chk("blk_head",  32'(bus_if.head_o),  32'd2);
        drive(1'b1, 4'd1, 3'd0, 1'b0);
        chk("unblk_accept", 32'(bus_if.dispAccept_o), 32'd1);
        chk("unblk_we",     32'(bus_if.we_o),         32'h1);
        chk("unblk_addr",   32'(bus_if.addrWr_o[3:0]), 32'd13);
        edge_step();
        chk("c12_count", 32'(bus_if.count_o), 32'd12);
        chk("c12_full",  32'(bus_if.full_o),  32'd0);

        // drain to head=12, tail=14, count=2
        drive(1'b0, 4'd0, 3'd4, 1'b0);
        edge_step();
        drive(1'b0, 4'd0, 3'd4, 1'b0);
        edge_step();
        drive(1'b0, 4'd0, 3'd2, 1'b0);
        chk("drain_err", 32'(bus_if.commitErr_o), 32'd0);
        edge_step();
        chk("w_head",   32'(bus_if.head_o),   32'd12);
        chk("w_count",  32'(bus_if.count_o),  32'd2);
        chk("w_addrRd", 32'(bus_if.addrRd_o), 32'hFEDC);

        // wrap: dispatch 4 and over-commit 4
        drive(1'b1, 4'd4, 3'd4, 1'b0);
        chk("w_addrWr", 32'(bus_if.addrWr_o),    32'h10FE);
        chk("w_we",     32'(bus_if.we_o),        32'hF);
        chk("w_alId",   32'(bus_if.alId_o),      32'd14);
        chk("w_err",    32'(bus_if.commitErr_o), 32'd1);
        edge_step();
        chk("w2_head",   32'(bus_if.head_o),        32'd14);
        chk("w2_count",  32'(bus_if.count_o),       32'd4);
        chk("w2_tail",   32'(bus_if.addrWr_o[3:0]), 32'd2);
        chk("w2_addrRd", 32'(bus_if.addrRd_o),      32'h10FE);

        // dispCnt above DISPATCH_WIDTH is clamped
        drive(1'b1, 4'd7, 3'd0, 1'b0);
        chk("clamp_we", 32'(bus_if.we_o), 32'hF);
        edge_step();
        chk("clamp_count", 32'(bus_if.count_o),       32'd8);
        chk("clamp_tail",  32'(bus_if.addrWr_o[3:0]), 32'd6);

        // flush overrides dispatch and commit
        drive(1'b1, 4'd2, 3'd3, 1'b1);
        chk("fl_we",     32'(bus_if.we_o),         32'd0);
        chk("fl_accept", 32'(bus_if.dispAccept_o), 32'd0);
        chk("fl_err",    32'(bus_if.commitErr_o),  32'd0);
        edge_step();
        chk("fl_head",  32'(bus_if.head_o),        32'd0);
        chk("fl_count", 32'(bus_if.count_o),       32'd0);
        chk("fl_tail",  32'(bus_if.addrWr_o[3:0]), 32'd0);
        chk("fl_empty", 32'(bus_if.empty_o),       32'd1);

        drive(1'b0, 4'd0, 3'd4, 1'b1);
        chk("fl_err_sup", 32'(bus_if.commitErr_o), 32'd0);
        edge_step();
        drive(1'b0, 4'd0, 3'd1, 1'b0);
        chk("empty_err", 32'(bus_if.commitErr_o), 32'd1);
        edge_step();
        chk("empty_err_count", 32'(bus_if.count_o), 32'd0);
        chk("empty_err_head",  32'(bus_if.head_o),  32'd0);

        // build count=9 then async reset between edges
        drive(1'b1, 4'd4, 3'd0, 1'b0);
        edge_step();
        drive(1'b1, 4'd4, 3'd0, 1'b0);
        edge_step();
        drive(1'b1, 4'd1, 3'd0, 1'b0);
        edge_step();
        chk("pre_rst_count", 32'(bus_if.count_o), 32'd9);
        drive(1'b0, 4'd0, 3'd0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_count", 32'(bus_if.count_o),       32'd0);
        chk("arst_empty", 32'(bus_if.empty_o),       32'd1);
        chk("arst_full",  32'(bus_if.full_o),        32'd0);
        chk("arst_tail",  32'(bus_if.addrWr_o[3:0]), 32'd0);

        drive(1'b0, 4'd0, 3'd0, 1'b0);
        reset = 1'b0;
        edge_step();
        chk("post_rst_count", 32'(bus_if.count_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
